// File: rtl/neuron_mac_if.sv
// neuron_mac_if: weight bank, activation stream and result handshake of the neuron MAC.
interface neuron_mac_if #(
    parameter int N_IN      = 10,
    parameter int W_WIDTH   = 8,
    parameter int X_WIDTH   = 8,
    parameter int ACC_WIDTH = 20
);
    logic [N_IN*W_WIDTH-1:0] weights;
    logic                    in_valid;
    logic                    in_ready;
    logic [X_WIDTH-1:0]      x_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    y_out;
    logic                    busy;
    modport master (output weights, in_valid, x_in, out_ready, input in_ready, out_valid, y_out, busy);
    modport slave  (input weights, in_valid, x_in, out_ready, output in_ready, out_valid, y_out, busy);
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: serial signed dot product of N_IN weights and streamed activations.
// Optional NEURON_RELU_EN clamps negative results to zero.
module neuron_mac #(
    parameter int N_IN      = 10,
    parameter int W_WIDTH   = 8,
    parameter int X_WIDTH   = 8,
    parameter int ACC_WIDTH = 20
) (
    input logic         clk,
    input logic         rst,
    neuron_mac_if.slave bus
);
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int PW = W_WIDTH + X_WIDTH;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t                       state;
    logic        [IW-1:0]         idx;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [W_WIDTH-1:0]    w [N_IN];
    logic signed [PW-1:0]         p;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  res;
    logic                         beat;
    logic                         last;
    for (genvar i = 0; i < N_IN; i++) begin : g_w
        assign w[i] = bus.weights[i*W_WIDTH +: W_WIDTH];
    end
    assign p    = w[idx] * $signed(bus.x_in);
    assign sum  = acc + {{(ACC_WIDTH-PW){p[PW-1]}}, p};
    assign beat = bus.in_valid & bus.in_ready;
    assign last = idx == IW'(N_IN - 1);
`ifdef NEURON_RELU_EN
    assign res = sum[ACC_WIDTH-1] ? '0 : sum;
`else
    assign res = sum;
`endif
    // acc is cleared when a result is handed off, so every frame starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            bus.y_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else if (beat) begin
            acc      <= sum;
            idx      <= idx + IW'(1);
            bus.busy <= 1'b1;
            state    <= last ? DONE : ACCUM;
            if (last) begin
                bus.y_out     <= res;
                bus.out_valid <= 1'b1;
                bus.in_ready  <= 1'b0;
            end
        end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized and directed checks of neuron_mac against a dot-product model.
module tb_neuron_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int asserts = 0;
    int fails = 0;
    logic signed [7:0] wv [10];
    logic signed [7:0] xv [10];

    neuron_mac_if bus ();
    neuron_mac dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [19:0] model();
        int s = 0;
        logic [19:0] r;
        for (int i = 0; i < 10; i++) s += int'(wv[i]) * int'(xv[i]);
        r = s[19:0];
`ifdef NEURON_RELU_EN
        if (r[19]) r = '0;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        for (int i = 0; i < 10; i++) bus.weights[i*8 +: 8] = wv[i];
    endtask

    task automatic send_frame(input int gap);
        load_weights();
        for (int i = 0; i < 10; i++) begin
            bus.x_in = xv[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            if (i < 9) repeat (gap) tick();
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        asserts++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.y_out !== 20'h0) begin
            fails++;
            $display("FAIL reset: out_valid=%b busy=%b y_out=%h, required 0 0 0", bus.out_valid, bus.busy, bus.y_out);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        asserts++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 10; i++) begin wv[i] = 8'sd1; xv[i] = 8'(i + 1); end
        send_frame(0);
        asserts++;
        if (bus.out_valid !== 1'b1 || bus.y_out !== 20'd55) begin
            fails++;
            $display("FAIL ones: out_valid=%b y_out=%0d, required 1 55", bus.out_valid, bus.y_out);
        end
        release_result();
        asserts++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ones_release: out_valid=%b busy=%b in_ready=%b, required 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_gaps();
        int bad = 0;
        for (int i = 0; i < 10; i++) begin wv[i] = 8'(i); xv[i] = 8'sd2; end
        load_weights();
        for (int i = 0; i < 10; i++) begin
            bus.x_in = xv[i];
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            asserts++;
            if (bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL gaps_busy: beat %0d busy=%b required 1", i, bus.busy);
            end
            if (i < 9) for (int g = 0; g < 3; g++) begin
                tick();
                if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) bad++;
            end
        end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL gaps_bubble: %0d bubble cycles with busy low or early out_valid, required 0", bad);
        end
        asserts++;
        if (bus.out_valid !== 1'b1 || bus.y_out !== 20'd90) begin
            fails++;
            $display("FAIL gaps: out_valid=%b y_out=%0d, required 1 90", bus.out_valid, bus.y_out);
        end
        release_result();
    endtask

    task automatic test_min_weight();
        logic [19:0] exp;
        for (int i = 0; i < 10; i++) begin wv[i] = 8'sd0; xv[i] = 8'sd0; end
        wv[0] = -8'sd128;
        xv[0] = 8'sd127;
`ifdef NEURON_RELU_EN
        exp = 20'h0;
`else
        exp = 20'hFC080;
`endif
        send_frame(1);
        asserts++;
        if (bus.y_out !== exp || bus.y_out !== model()) begin
            fails++;
            $display("FAIL min_weight: y_out=%h required %h", bus.y_out, exp);
        end
        release_result();
    endtask

    task automatic test_all_min();
        for (int i = 0; i < 10; i++) begin wv[i] = -8'sd128; xv[i] = -8'sd128; end
        send_frame(0);
        asserts++;
        if (bus.y_out !== 20'h28000) begin
            fails++;
            $display("FAIL all_min: y_out=%h required 28000", bus.y_out);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        logic [19:0] exp;
        for (int i = 0; i < 10; i++) begin wv[i] = 8'($urandom); xv[i] = 8'($urandom); end
        exp = model();
        send_frame(0);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.x_in = 8'($urandom);
            tick();
            asserts++;
            if (bus.out_valid !== 1'b1 || bus.y_out !== exp || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL backpressure: cycle %0d out_valid=%b y_out=%h in_ready=%b busy=%b, required 1 %h 0 1", c, bus.out_valid, bus.y_out, bus.in_ready, bus.busy, exp);
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        asserts++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
        end
        for (int i = 0; i < 10; i++) begin wv[i] = 8'($urandom); xv[i] = 8'($urandom); end
        send_frame(0);
        asserts++;
        if (bus.y_out !== model()) begin
            fails++;
            $display("FAIL backpressure_next: y_out=%h required %h", bus.y_out, model());
        end
        release_result();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 10; i++) begin wv[i] = 8'sd1; xv[i] = 8'(i + 1); end
        load_weights();
        for (int i = 0; i < 4; i++) begin
            bus.x_in = xv[i];
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        asserts++;
        if (bus.y_out !== 20'h0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: y_out=%h out_valid=%b busy=%b, required 0 0 0", bus.y_out, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_frame(0);
        asserts++;
        if (bus.out_valid !== 1'b1 || bus.y_out !== 20'd55) begin
            fails++;
            $display("FAIL reset_mid_repeat: out_valid=%b y_out=%0d, required 1 55", bus.out_valid, bus.y_out);
        end
        release_result();
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 10; i++) begin wv[i] = 8'($urandom); xv[i] = 8'($urandom); end
            asserts++;
            if (bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL random_ready: frame %0d in_ready=%b required 1", f, bus.in_ready);
            end
            send_frame(int'($urandom_range(0, 2)));
            asserts++;
            if (bus.out_valid !== 1'b1 || bus.y_out !== model()) begin
                fails++;
                $display("FAIL random: frame %0d out_valid=%b y_out=%h, required 1 %h", f, bus.out_valid, bus.y_out, model());
            end
            repeat ($urandom_range(0, 3)) tick();
            release_result();
        end
    endtask

    initial begin
        bus.weights = '0;
        bus.in_valid = 1'b0;
        bus.x_in = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ones();
        test_gaps();
        test_min_weight();
        test_all_min();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
